// File: rtl/op_unit_scheduler.sv
// Round-robin scheduler that shares one operation unit among NUM_USERS requesters,
// running one grant/issue/wait/respond sequence at a time with a response timeout.
module op_unit_scheduler #(
  parameter int NUM_USERS      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_USERS-1:0]     user_req,
  input  logic [2*NUM_USERS-1:0]   user_op_code,
  input  logic [8*NUM_USERS-1:0]   user_data,
  output logic [NUM_USERS-1:0]     user_grant,
  output logic [NUM_USERS-1:0]     resp_valid,
  output logic [7:0]               resp_data,
  output logic                     resp_err,
  output logic                     ou_op_start,
  output logic [1:0]               ou_op_code,
  output logic [7:0]               ou_data_in,
  input  logic [7:0]               ou_data_out,
  input  logic                     ou_data_valid,
  output logic                     busy
);

  localparam int IDX_W = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_USER = IDX_W'(NUM_USERS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] sel;
  logic [CNT_W-1:0] cnt;

  logic             found;
  logic [IDX_W-1:0] sel_next;
  logic [IDX_W-1:0] cand;
  logic [1:0]       req_op;
  logic [7:0]       req_data;

  // Scan starting one past the last winner so the previous winner ends up lowest priority.
  always_comb begin
    found    = 1'b0;
    sel_next = '0;
    cand     = last_grant;
    req_op   = '0;
    req_data = '0;
    for (int k = 0; k < NUM_USERS; k++) begin
      cand = (cand == LAST_USER) ? '0 : cand + IDX_W'(1);
      if (!found && user_req[cand]) begin
        found    = 1'b1;
        sel_next = cand;
      end
    end
    for (int i = 0; i < NUM_USERS; i++) begin
      if (sel_next == IDX_W'(i)) begin
        req_op   = user_op_code[2*i +: 2];
        req_data = user_data[8*i +: 8];
      end
    end
  end

  // Outputs are set on the edge entering the state they belong to, so each is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      last_grant  <= LAST_USER;
      sel         <= '0;
      cnt         <= '0;
      user_grant  <= '0;
      resp_valid  <= '0;
      resp_data   <= '0;
      resp_err    <= 1'b0;
      ou_op_start <= 1'b0;
      ou_op_code  <= '0;
      ou_data_in  <= '0;
      busy        <= 1'b0;
    end else begin
      user_grant  <= '0;
      resp_valid  <= '0;
      resp_data   <= '0;
      resp_err    <= 1'b0;
      ou_op_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            user_grant <= NUM_USERS'(1) << sel_next;
            sel        <= sel_next;
            last_grant <= sel_next;
            ou_op_code <= req_op;
            ou_data_in <= req_data;
            busy       <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          ou_op_start <= 1'b1;
          cnt         <= '0;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          // A result arriving on the last allowed cycle still beats the timeout.
          if (ou_data_valid) begin
            resp_valid <= NUM_USERS'(1) << sel;
            resp_data  <= ou_data_out;
            resp_err   <= 1'b0;
            state      <= ST_RESP;
          end else if (cnt == CNT_LAST) begin
            resp_valid <= NUM_USERS'(1) << sel;
            resp_data  <= 8'h00;
            resp_err   <= 1'b1;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_op_unit_scheduler.sv
// Bench for op_unit_scheduler: cycle-by-cycle vector table plus directed sequences for
// fairness, timeout, reset during WAIT, stray result strobes and operand stability.
module tb_op_unit_scheduler;

  localparam int USERS   = 4;
  localparam int TIMEOUT = 16;

  logic                 clk;
  logic                 rst;
  logic [USERS-1:0]     user_req;
  logic [2*USERS-1:0]   user_op_code;
  logic [8*USERS-1:0]   user_data;
  logic [USERS-1:0]     user_grant;
  logic [USERS-1:0]     resp_valid;
  logic [7:0]           resp_data;
  logic                 resp_err;
  logic                 ou_op_start;
  logic [1:0]           ou_op_code;
  logic [7:0]           ou_data_in;
  logic [7:0]           ou_data_out;
  logic                 ou_data_valid;
  logic                 busy;

  logic                 stub_mode;
  logic                 stub_valid;
  logic [7:0]           stub_data;

  int n_compared;
  int n_mismatched;

  op_unit_scheduler #(.NUM_USERS(USERS), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .user_req     (user_req),
    .user_op_code (user_op_code),
    .user_data    (user_data),
    .user_grant   (user_grant),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .ou_op_start  (ou_op_start),
    .ou_op_code   (ou_op_code),
    .ou_data_in   (ou_data_in),
    .ou_data_out  (ou_data_out),
    .ou_data_valid(ou_data_valid),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference operation unit: pass, shift left 2, rotate right 2, invert.
  function automatic logic [7:0] opModel(input logic [1:0] op, input logic [7:0] d);
    case (op)
      2'b00:   opModel = d;
      2'b01:   opModel = {d[5:0], 2'b00};
      2'b10:   opModel = {d[1:0], d[7:2]};
      default: opModel = ~d;
    endcase
  endfunction

  assign ou_data_valid = stub_mode ? stub_valid : ou_op_start;
  assign ou_data_out   = stub_mode ? stub_data  : opModel(ou_op_code, ou_data_in);

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  ops;
    logic [31:0] dat;
    logic [3:0]  grant;
    logic        start;
    logic [3:0]  rvalid;
    logic [7:0]  rdata;
    logic        rerr;
    logic        busy;
    logic [1:0]  op;
    logic [7:0]  din;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] fair_seq[$];

  task automatic addVec(input logic r, input logic [3:0] rq, input logic [7:0] ops,
                        input logic [31:0] dat, input logic [3:0] g, input logic st,
                        input logic [3:0] rv, input logic [7:0] rd, input logic re,
                        input logic bz, input logic [1:0] op, input logic [7:0] din);
    vec_t v;
    v.rst = r;  v.req = rq;  v.ops = ops;  v.dat = dat;
    v.grant = g; v.start = st; v.rvalid = rv; v.rdata = rd;
    v.rerr = re; v.busy = bz; v.op = op; v.din = din;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst          = v.rst;
    user_req     = v.req;
    user_op_code = v.ops;
    user_data    = v.dat;
    @(negedge clk);
  endtask

  task automatic checkVec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    checkOutput({tag, "_grant"}, 32'(user_grant),  32'(v.grant));
    checkOutput({tag, "_start"}, 32'(ou_op_start), 32'(v.start));
    checkOutput({tag, "_rvalid"}, 32'(resp_valid), 32'(v.rvalid));
    checkOutput({tag, "_rdata"}, 32'(resp_data),   32'(v.rdata));
    checkOutput({tag, "_rerr"},  32'(resp_err),    32'(v.rerr));
    checkOutput({tag, "_busy"},  32'(busy),        32'(v.busy));
    checkOutput({tag, "_op"},    32'(ou_op_code),  32'(v.op));
    checkOutput({tag, "_din"},   32'(ou_data_in),  32'(v.din));
  endtask

  task automatic doReset();
    rst      = 1'b1;
    user_req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    bit got;
    n_compared   = 0;
    n_mismatched = 0;
    rst          = 1'b1;
    user_req     = '0;
    user_op_code = '0;
    user_data    = '0;
    stub_mode    = 1'b0;
    stub_valid   = 1'b0;
    stub_data    = '0;

    // Reset, then a single op from user 0 (op 01 on 0xCC gives 0x30).
    addVec(1, 4'b0000, 8'h00, 32'h0,  4'b0000, 0, 4'b0000, 8'h00, 0, 0, 2'b00, 8'h00);
    addVec(0, 4'b0001, 8'h01, 32'hCC, 4'b0001, 0, 4'b0000, 8'h00, 0, 1, 2'b01, 8'hCC);
    addVec(0, 4'b0000, 8'h01, 32'hCC, 4'b0000, 1, 4'b0000, 8'h00, 0, 1, 2'b01, 8'hCC);
    addVec(0, 4'b0000, 8'h01, 32'hCC, 4'b0000, 0, 4'b0001, 8'h30, 0, 1, 2'b01, 8'hCC);
    addVec(0, 4'b0000, 8'h01, 32'hCC, 4'b0000, 0, 4'b0000, 8'h00, 0, 0, 2'b01, 8'hCC);
    // Reset, then all four users at once; each drops its request after its grant.
    addVec(1, 4'b0000, 8'hE4, 32'h55B3CCAA, 4'b0000, 0, 4'b0000, 8'h00, 0, 0, 2'b00, 8'h00);
    addVec(0, 4'b1111, 8'hE4, 32'h55B3CCAA, 4'b0001, 0, 4'b0000, 8'h00, 0, 1, 2'b00, 8'hAA);
    addVec(0, 4'b1110, 8'hE4, 32'h55B3CCAA, 4'b0000, 1, 4'b0000, 8'h00, 0, 1, 2'b00, 8'hAA);
    addVec(0, 4'b1110, 8'hE4, 32'h55B3CCAA, 4'b0000, 0, 4'b0001, 8'hAA, 0, 1, 2'b00, 8'hAA);
    addVec(0, 4'b1110, 8'hE4, 32'h55B3CCAA, 4'b0000, 0, 4'b0000, 8'h00, 0, 0, 2'b00, 8'hAA);
    addVec(0, 4'b1110, 8'hE4, 32'h55B3CCAA, 4'b0010, 0, 4'b0000, 8'h00, 0, 1, 2'b01, 8'hCC);
    addVec(0, 4'b1100, 8'hE4, 32'h55B3CCAA, 4'b0000, 1, 4'b0000, 8'h00, 0, 1, 2'b01, 8'hCC);
    addVec(0, 4'b1100, 8'hE4, 32'h55B3CCAA, 4'b0000, 0, 4'b0010, 8'h30, 0, 1, 2'b01, 8'hCC);
    addVec(0, 4'b1100, 8'hE4, 32'h55B3CCAA, 4'b0000, 0, 4'b0000, 8'h00, 0, 0, 2'b01, 8'hCC);
    addVec(0, 4'b1100, 8'hE4, 32'h55B3CCAA, 4'b0100, 0, 4'b0000, 8'h00, 0, 1, 2'b10, 8'hB3);
    addVec(0, 4'b1000, 8'hE4, 32'h55B3CCAA, 4'b0000, 1, 4'b0000, 8'h00, 0, 1, 2'b10, 8'hB3);
    addVec(0, 4'b1000, 8'hE4, 32'h55B3CCAA, 4'b0000, 0, 4'b0100, 8'hEC, 0, 1, 2'b10, 8'hB3);
    addVec(0, 4'b1000, 8'hE4, 32'h55B3CCAA, 4'b0000, 0, 4'b0000, 8'h00, 0, 0, 2'b10, 8'hB3);
    addVec(0, 4'b1000, 8'hE4, 32'h55B3CCAA, 4'b1000, 0, 4'b0000, 8'h00, 0, 1, 2'b11, 8'h55);
    addVec(0, 4'b0000, 8'hE4, 32'h55B3CCAA, 4'b0000, 1, 4'b0000, 8'h00, 0, 1, 2'b11, 8'h55);
    addVec(0, 4'b0000, 8'hE4, 32'h55B3CCAA, 4'b0000, 0, 4'b1000, 8'hAA, 0, 1, 2'b11, 8'h55);
    addVec(0, 4'b0000, 8'hE4, 32'h55B3CCAA, 4'b0000, 0, 4'b0000, 8'h00, 0, 0, 2'b11, 8'h55);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkVec(i, vecs[i]);
    end

    // Fairness: users 1 and 2 hold their requests across six operations.
    doReset();
    user_op_code = 8'h00;
    user_data    = 32'h04030201;
    user_req     = 4'b0110;
    for (int c = 0; c < 60 && fair_seq.size() < 6; c++) begin
      @(negedge clk);
      if (user_grant != '0) fair_seq.push_back(user_grant);
    end
    user_req = '0;
    checkOutput("fair_count", fair_seq.size(), 6);
    for (int i = 0; i < fair_seq.size(); i++)
      checkOutput($sformatf("fair_grant%0d", i), 32'(fair_seq[i]),
                  (i % 2 == 0) ? 32'h2 : 32'h4);
    repeat (4) @(negedge clk);
    checkOutput("fair_idle_busy", 32'(busy), 0);

    // Timeout: the unit never answers; user 3 is next in rotation after user 2.
    stub_mode  = 1'b1;
    stub_valid = 1'b0;
    stub_data  = 8'h77;
    user_req   = 4'b1000;
    @(negedge clk);
    checkOutput("to_grant", 32'(user_grant), 32'h8);
    user_req = '0;
    @(negedge clk);
    checkOutput("to_start", 32'(ou_op_start), 1);
    waited = 0;
    got    = 1'b0;
    for (int k = 1; k <= 3 * TIMEOUT && !got; k++) begin
      @(negedge clk);
      if (resp_valid != '0) begin
        got    = 1'b1;
        waited = k;
      end
    end
    checkOutput("to_latency", waited, TIMEOUT);
    checkOutput("to_rvalid", 32'(resp_valid), 32'h8);
    checkOutput("to_rerr", 32'(resp_err), 1);
    checkOutput("to_rdata", 32'(resp_data), 0);
    @(negedge clk);

    // After a timeout the next request is served normally (op 11 on 0x0F gives 0xF0).
    stub_mode    = 1'b0;
    user_op_code = 8'h03;
    user_data    = 32'h0000000F;
    user_req     = 4'b0001;
    @(negedge clk);
    checkOutput("post_to_grant", 32'(user_grant), 32'h1);
    user_req = '0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("post_to_rvalid", 32'(resp_valid), 32'h1);
    checkOutput("post_to_rdata", 32'(resp_data), 32'hF0);
    checkOutput("post_to_rerr", 32'(resp_err), 0);
    @(negedge clk);

    // Reset while waiting: a late result strobe must not produce a response.
    stub_mode  = 1'b1;
    stub_valid = 1'b0;
    user_req   = 4'b0100;
    @(negedge clk);
    checkOutput("rw_grant", 32'(user_grant), 32'h4);
    user_req = '0;
    repeat (3) @(negedge clk);
    checkOutput("rw_busy_before", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rw_rst_grant", 32'(user_grant), 0);
    checkOutput("rw_rst_busy", 32'(busy), 0);
    checkOutput("rw_rst_op", 32'(ou_op_code), 0);
    checkOutput("rw_rst_din", 32'(ou_data_in), 0);
    checkOutput("rw_rst_rvalid", 32'(resp_valid), 0);
    stub_valid = 1'b1;
    stub_data  = 8'h5A;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rw_late_rvalid%0d", k), 32'(resp_valid), 0);
      checkOutput($sformatf("rw_late_busy%0d", k), 32'(busy), 0);
    end
    stub_valid   = 1'b0;
    stub_mode    = 1'b0;
    user_op_code = 8'h00;
    user_data    = 32'h0;
    user_req     = 4'b1111;
    @(negedge clk);
    checkOutput("rw_first_grant", 32'(user_grant), 32'h1);
    user_req = '0;
    repeat (3) @(negedge clk);

    // Stray strobe in IDLE, then operands changed right after the grant.
    stub_mode  = 1'b1;
    stub_valid = 1'b1;
    stub_data  = 8'h99;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput($sformatf("stray_rvalid%0d", k), 32'(resp_valid), 0);
      checkOutput($sformatf("stray_busy%0d", k), 32'(busy), 0);
    end
    stub_valid   = 1'b0;
    stub_mode    = 1'b0;
    user_op_code = 8'b0000_0100;
    user_data    = 32'h0000_1100;
    user_req     = 4'b0010;
    @(negedge clk);
    checkOutput("chg_grant", 32'(user_grant), 32'h2);
    user_op_code = 8'b0000_1100;
    user_data    = 32'h0000_FF00;
    user_req     = '0;
    @(negedge clk);
    checkOutput("chg_start", 32'(ou_op_start), 1);
    checkOutput("chg_op", 32'(ou_op_code), 1);
    checkOutput("chg_din", 32'(ou_data_in), 32'h11);
    @(negedge clk);
    checkOutput("chg_rvalid", 32'(resp_valid), 32'h2);
    checkOutput("chg_rdata", 32'(resp_data), 32'h44);
    checkOutput("chg_rerr", 32'(resp_err), 0);
    @(negedge clk);
    checkOutput("chg_idle_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/op_unit_scheduler.md
Name: op_unit_scheduler

Overview:
- Shares one operation unit (2-bit op_code, 8-bit data, op_start/data_valid interface) among NUM_USERS requesters.
- Round-robin arbitration; sequences exactly one operation at a time: grant, issue, wait for result, return.
- Sits between the user-side request ports and the operation unit; also flags a unit that never responds.

Parameters:
- NUM_USERS, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 16, max cycles in WAIT before abort (>=2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- user_req  input  NUM_USERS  per-user request level; held until that user's grant.
- user_op_code  input  2*NUM_USERS  packed op codes, user i at [2i+1:2i].
- user_data  input  8*NUM_USERS  packed operands, user i at [8i+7:8i].
- user_grant  output  NUM_USERS  one-hot, one-cycle pulse: request accepted, operands latched.
- resp_valid  output  NUM_USERS  one-hot, one-cycle pulse to the served user.
- resp_data  output  8  result, valid with resp_valid.
- resp_err  output  1  qualifies resp_valid: 1 = timeout, resp_data = 0x00.
- ou_op_start  output  1  one-cycle start to operation unit.
- ou_op_code  output  2  latched op code, stable from ISSUE until return to IDLE.
- ou_data_in  output  8  latched operand, same stability.
- ou_data_out  input  8  operation unit result.
- ou_data_valid  input  1  operation unit result strobe.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE; all outputs 0; last_grant=NUM_USERS-1 so user 0 has top priority first; timeout counter=0; latched op/data=0. Reset in any state (incl. mid-WAIT) aborts silently: no resp_valid issued, pending ou_data_valid afterwards ignored.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any user_req, select first requester scanning from (last_grant+1) mod NUM_USERS upward with wrap; pulse user_grant[sel], latch sel, op_code, data; last_grant<=sel; next=ISSUE. No request: stay, outputs 0.
- ISSUE: ou_op_start=1 for exactly this cycle; counter<=0; next=WAIT.
- WAIT: ou_data_valid=1 -> capture ou_data_out, next=RESP (err=0). Else counter++; when counter reaches TIMEOUT_CYCLES-1 with no valid -> next=RESP with err=1, captured data 0x00. Valid and timeout in the same cycle: valid wins.
- RESP: resp_valid[sel]=1, resp_data=captured, resp_err=err, one cycle; next=IDLE.
- ou_data_valid outside WAIT is ignored (no state change, no response).
- Minimum throughput: 4 cycles per operation (grant, issue, wait with valid on first WAIT cycle, resp); next grant earliest in cycle after RESP.
- user_req dropped before grant = withdrawn, no side effects. user_req from the served user re-asserted during service is treated as a new request, arbitrated normally (lowest priority next round).
- user_op_code/user_data sampled only in grant cycle; later changes do not affect the in-flight operation.
- All outputs registered; no combinational path from user inputs to ou_* outputs.

Test Plan:
- Single user 0, op 2'b01, data 0xCC, real operation unit -> user_grant[0] one pulse, ou_op_start one pulse next cycle, resp_valid[0] with resp_data 0x30, resp_err=0; busy high 3 cycles.
- Users 0..3 request simultaneously with (00,0xAA),(01,0xCC),(10,0xB3),(11,0x55) -> grants in order 0,1,2,3; responses 0xAA, 0x30, 0xEC, 0xAA to matching one-hot resp_valid.
- Fairness: users 1 and 2 hold req continuously for 6 operations -> grants alternate 1,2,1,2,1,2; never two consecutive grants to one user.
- Timeout: stub unit never asserts ou_data_valid -> resp_valid[sel] with resp_err=1, resp_data 0x00 exactly TIMEOUT_CYCLES cycles after entering WAIT; next request then served normally.
- Reset mid-WAIT: rst=1 for one cycle while waiting, stub then asserts ou_data_valid -> no resp_valid, all outputs 0, next grant goes to user 0 first.
- Stray ou_data_valid in IDLE, and user_data changed after grant -> no response generated; in-flight result uses the grant-cycle operand.
